// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package instr_loader_pkg;

  localparam int unsigned AddrWDefault = 5;
  localparam int unsigned DataWDefault = 16;
  localparam int unsigned CsumW        = 8;
  localparam bit          HighByteFirst = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StHi,
    StLo,
    StWrite,
    StChk,
    StRun,
    StErr
  } state_e;

  // Assemble a 16-bit instruction from two bytes in arrival order.
  function automatic logic [15:0] pack_word(input logic [7:0] first, input logic [7:0] second);
    return HighByteFirst ? {first, second} : {second, first};
  endfunction

endpackage

// File: rtl/instr_loader_xor_checksum.sv
// 8-bit XOR accumulator with clear/enable and an equality compare against a probe byte.
module instr_loader_xor_checksum
  import instr_loader_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [CsumW-1:0] din,
  input  logic [CsumW-1:0] cmp,
  output logic             match
);

  logic [CsumW-1:0] sum_q;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      sum_q <= '0;
    end else if (en) begin
      sum_q <= sum_q ^ din;
    end
  end

  assign match = (sum_q == cmp);

endmodule

// File: rtl/instr_loader.sv
// Packs a host byte stream into instructions, writes them to imem, verifies an XOR checksum
// and only then releases the core.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_len,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              core_rst,
  output logic              core_run,
  output logic              load_err
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        first_q, first_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rst_q, rst_d;
  logic              run_q, run_d;
  logic              err_q, err_d;
  logic              accept;
  logic              cs_clear, cs_en, cs_match;

  instr_loader_xor_checksum u_csum (
    .clock (clock),
    .reset (reset),
    .clear (cs_clear),
    .en    (cs_en),
    .din   (in_byte),
    .cmp   (in_byte),
    .match (cs_match)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    first_d  = first_q;
    we_d     = 1'b0;
    waddr_d  = '0;
    wdata_d  = '0;
    rst_d    = 1'b0;
    run_d    = 1'b0;
    err_d    = 1'b0;
    cs_clear = 1'b0;
    cs_en    = 1'b0;
    // load_start wins over a byte offered in the same cycle.
    in_ready = ((state_q == StHi) || (state_q == StLo) || (state_q == StChk)) && !load_start;
    accept   = in_ready && in_valid;

    if (load_start) begin
      state_d  = StHi;
      cnt_d    = load_len;
      addr_d   = '0;
      cs_clear = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: ;
        StHi: begin
          if (accept) begin
            first_d = in_byte;
            cs_en   = 1'b1;
            state_d = StLo;
          end
        end
        StLo: begin
          if (accept) begin
            cs_en   = 1'b1;
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = DATA_W'(pack_word(first_q, in_byte));
            state_d = StWrite;
          end
        end
        StWrite: begin
          if (cnt_q == '0) begin
            state_d = StChk;
          end else begin
            cnt_d   = cnt_q - 1'b1;
            addr_d  = addr_q + 1'b1;
            state_d = StHi;
          end
        end
        StChk: begin
          if (accept) begin
            if (cs_match) begin
              state_d = StRun;
              rst_d   = 1'b1;
              run_d   = 1'b1;
            end else begin
              state_d = StErr;
              err_d   = 1'b1;
            end
          end
        end
        StRun:   run_d = 1'b1;
        StErr:   err_d = 1'b1;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      first_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      rst_q   <= 1'b0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      first_q <= first_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      rst_q   <= rst_d;
      run_q   <= run_d;
      err_q   <= err_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = waddr_q;
  assign imem_wdata = wdata_q;
  assign core_rst   = rst_q;
  assign core_run   = run_q;
  assign load_err   = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: captures writes at the falling edge and checks them
// against hand-computed expectations.
module tb_instr_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load_start = 1'b0;
  logic [4:0]  load_len = '0;
  logic [7:0]  in_byte = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        imem_we;
  logic [4:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        core_rst;
  logic        core_run;
  logic        load_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rst_cycles = 0;
  int rst_with_run = 0;
  int ready_in_write = 0;
  logic [4:0]  wa[$];
  logic [15:0] wd[$];

  instr_loader dut (
    .clock      (clock),
    .reset      (reset),
    .load_start (load_start),
    .load_len   (load_len),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .core_run   (core_run),
    .load_err   (load_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (imem_we) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
      if (in_ready) ready_in_write++;
    end
    if (core_rst) begin
      rst_cycles++;
      if (core_run) rst_with_run++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    rst_cycles = 0;
    rst_with_run = 0;
    ready_in_write = 0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clock);
    check({tag, "_ready"}, in_ready, 0);
    check({tag, "_we"}, imem_we, 0);
    check({tag, "_addr"}, imem_addr, 0);
    check({tag, "_wdata"}, imem_wdata, 0);
    check({tag, "_crst"}, core_rst, 0);
    check({tag, "_run"}, core_run, 0);
    check({tag, "_err"}, load_err, 0);
  endtask

  // Pulse load_start for one cycle; optionally offer a colliding byte that must be refused.
  task automatic start_load(input logic [4:0] len, input bit collide);
    load_start = 1'b1;
    load_len   = len;
    if (collide) begin
      in_byte  = 8'hEE;
      in_valid = 1'b1;
      @(negedge clock);
      check("collide_ready", in_ready, 0);
    end
    next_cycle();
    load_start = 1'b0;
    in_valid   = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int   n   = 0;
    logic got = 1'b0;
    in_byte  = b;
    in_valid = 1'b1;
    while (!got && n < 50) begin
      @(negedge clock);
      got = in_ready;
      next_cycle();
      n++;
    end
    in_valid = 1'b0;
    if (!got) check("accept_timeout", 0, 1);
  endtask

  task automatic single_word(input string tag, input logic [7:0] csum, input bit stall);
    clear_log();
    start_load(5'd0, 1'b0);
    send_byte(8'h12);
    if (stall) next_cycle();
    send_byte(8'h34);
    if (stall) next_cycle();
    send_byte(csum);
    next_cycle();
    next_cycle();
    @(negedge clock);
    check({tag, "_nwr"}, wa.size(), 1);
    if (wa.size() == 1) begin
      check({tag, "_addr"}, wa[0], 0);
      check({tag, "_data"}, wd[0], 16'h1234);
    end
    check({tag, "_ready_wr"}, ready_in_write, 0);
  endtask

  initial begin
    int c0;
    repeat (3) next_cycle();
    reset = 1'b0;
    check_idle("reset");

    single_word("single", 8'h26, 1'b0);
    check("single_rst", rst_cycles, 1);
    check("single_rst_run", rst_with_run, 1);
    check("single_run", core_run, 1);
    check("single_err", load_err, 0);

    single_word("badcs", 8'h27, 1'b0);
    repeat (4) next_cycle();
    @(negedge clock);
    check("badcs_rst", rst_cycles, 0);
    check("badcs_run", core_run, 0);
    check("badcs_err", load_err, 1);

    clear_log();
    start_load(5'd31, 1'b0);
    check("full_err_cleared", load_err, 0);
    c0 = cyc;
    for (int i = 0; i < 32; i++) begin
      send_byte(8'h00);
      send_byte(8'(i));
    end
    send_byte(8'h00);
    check("full_cycles", cyc - c0, 97);
    next_cycle();
    @(negedge clock);
    check("full_nwr", wa.size(), 32);
    for (int i = 0; i < 32 && i < wa.size(); i++) begin
      check("full_addr", wa[i], i);
      check("full_data", wd[i], i);
    end
    check("full_run", core_run, 1);
    check("full_err", load_err, 0);

    single_word("stall", 8'h26, 1'b1);
    check("stall_rst", rst_cycles, 1);
    check("stall_run", core_run, 1);

    clear_log();
    start_load(5'd3, 1'b0);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    start_load(5'd0, 1'b0);
    check("abort_run_dropped", core_run, 0);
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_byte(8'h66);
    next_cycle();
    @(negedge clock);
    check("abort_nwr", wa.size(), 3);
    if (wa.size() == 3) begin
      check("abort_a0", wa[0], 0);
      check("abort_d0", wd[0], 16'h1122);
      check("abort_a1", wa[1], 1);
      check("abort_d1", wd[1], 16'h3344);
      check("abort_a2", wa[2], 0);
      check("abort_d2", wd[2], 16'hABCD);
    end
    check("abort_run", core_run, 1);

    clear_log();
    start_load(5'd0, 1'b0);
    start_load(5'd0, 1'b1);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h26);
    next_cycle();
    @(negedge clock);
    check("collide_nwr", wa.size(), 1);
    if (wa.size() == 1) check("collide_data", wd[0], 16'h1234);
    check("collide_run", core_run, 1);

    clear_log();
    start_load(5'd1, 1'b0);
    send_byte(8'h12);
    in_byte  = 8'h34;
    in_valid = 1'b1;
    reset    = 1'b1;
    next_cycle();
    in_valid = 1'b0;
    check_idle("rst_mid");
    check("rst_mid_nwr", wa.size(), 0);
    reset = 1'b0;
    next_cycle();
    single_word("after_rst", 8'h26, 1'b0);
    check("after_rst_run", core_run, 1);

    reset = 1'b1;
    next_cycle();
    check_idle("rst_run");
    reset = 1'b0;
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Program loader that writes the instruction memory of the autoencoder core: the write side of the memory that the core's program counter reads. It accepts a byte stream from a host over a valid/ready handshake and packs bytes into 16-bit instructions (opcode nibble first). It writes each word to consecutive instruction addresses, verifies an XOR checksum, and only then releases the core to run. It sits between the host link and the instruction memory / program-counter register.

## Interface
- ADDR_W, default 5: instruction address width; must match the 5-bit program counter.
- DATA_W, default 16: instruction width (opcode, field 1, field 2, field 3; 4 bits each).
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- load_start  in  1  one-cycle pulse that begins a load; it is honoured in every state.
- load_len  in  ADDR_W  sampled with load_start; the number of words is load_len+1 (1..32).
- in_byte  in  8  host data byte.
- in_valid  in  1  in_byte is valid.
- in_ready  out  1  the loader accepts a byte this cycle.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  write address.
- imem_wdata  out  DATA_W  write data.
- core_rst  out  1  one-cycle pulse that clears the program counter before a run.
- core_run  out  1  held high while the loaded program is valid and the core may execute.
- load_err  out  1  held high after a checksum mismatch, until the next load_start or reset.

## Operation
- States: IDLE, HI, LO, WRITE, CHK, RUN, ERR.
- A byte is accepted only when in_valid and in_ready are both high. in_ready is high only in HI, LO and CHK.
- IDLE: all outputs are low. On load_start:
  - latch load_len into the word counter;
  - clear the address and the checksum;
  - go to HI.
- HI: on accept, store in_byte as word[15:8], XOR it into the checksum, go to LO.
- LO: on accept, store in_byte as word[7:0], XOR it into the checksum, go to WRITE.
- WRITE: for exactly one cycle, imem_we=1, imem_addr=current address and imem_wdata=assembled word.
  - If this is the last word, go to CHK.
  - Otherwise increment the address and go to HI.
- CHK: on accept, compare in_byte with the checksum.
  - On a match, go to RUN and pulse core_rst for one cycle.
  - On a mismatch, go to ERR.
- RUN: core_run=1. Remain here until load_start.
- ERR: load_err=1. Remain here until load_start.
- load_start in any state aborts the current activity, drops core_run and load_err, and restarts the load. A partially written program is never run.
- The address never wraps. With load_len=31, the write to address 31 goes straight to CHK.
- Checksum: 8-bit XOR of all 2*(load_len+1) data bytes. The checksum byte itself is excluded.

## Timing
- Reset: state=IDLE, and every output (in_ready, imem_we, imem_addr, imem_wdata, core_rst, core_run, load_err) is 0. The address, word counter and checksum are also 0.
- All outputs are registered.
- Accepting the low byte at edge t drives imem_we high for the cycle after t.
- Throughput: 2 bytes per 3 cycles when in_valid is held high.
- After the checksum is accepted at edge t:
  - core_rst is high for exactly one cycle after t;
  - core_run rises in the same cycle and stays high.
- If load_start and in_valid arrive in the same cycle, load_start wins and the byte is not accepted (in_ready is low that cycle).
- Gaps in in_valid stall HI, LO or CHK indefinitely with no side effects.
- Reset asserted mid-load returns the block to the reset state on the next edge. No write strobe is issued in that cycle.

## Structure
- A shared package holds:
  - the state enumeration;
  - ADDR_W/DATA_W defaults;
  - the byte-order constant (high byte first);
  - the checksum width.
- One natural sub-module is `xor_checksum`: an 8-bit accumulator with clear and accumulate-enable, and a compare output. Everything else lives in the FSM.

## Test plan
- Single word: load_len=0; send bytes 0x12, 0x34, 0x26.
  - Expect one write: addr 0, data 0x1234.
  - Expect core_rst pulsed for one cycle, then core_run=1 and load_err=0.
- Bad checksum: same as above but the checksum byte is 0x27.
  - Expect the write to addr 0 to occur.
  - Expect core_run to stay 0 and load_err=1 to be held.
- Full depth: load_len=31; send words 0x0000..0x001F with in_valid high throughout, then the correct checksum.
  - Expect 32 writes to addr 0..31, each with data equal to its address.
  - Expect no wrap and core_run=1.
- Stalls: repeat the single-word case with in_valid toggling every other cycle.
  - Expect the same writes and result.
  - Expect in_ready to be low during the WRITE cycle.
- Abort: start load_len=3; after two words, pulse load_start with load_len=0; send 0xAB, 0xCD, 0x66.
  - Expect writes at addr 0, 1 from the first load, then addr 0 = 0xABCD.
  - Expect core_run=1.
- Reset mid-load, and reset while in RUN: expect all outputs 0 on the next cycle and state IDLE. A subsequent load completes normally.
